// File: rtl/systolic_array_stream.sv
// Output-stationary GEMM engine: C = A x B with A (ROWS x K) and B (K x COLS).
// Operand beats (one A column, one B row) stream in, are skewed across the PE
// grid, accumulated in place, then drained one result row at a time over a
// backpressurable output stream.
module systolic_array_stream #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int IP_W  = 8,
  parameter int ACC_W = 32,
  parameter int K_MAX = 1024,
  localparam int KW   = $clog2(K_MAX + 1),
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic                  signed_mode,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROWS*IP_W-1:0]  a_vec,
  input  logic [COLS*IP_W-1:0]  b_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLS*ACC_W-1:0] out_data,
  output logic [RW-1:0]         out_row,
  output logic                  out_last,
  output logic                  done,
  output logic [31:0]           cycles_count
);

  localparam int FW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t          state, state_n;
  logic [KW-1:0]   k_r;
  logic            mode_r;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic            job_start;
  logic            row_last;

  logic signed [IP_W-1:0]  inj_a [ROWS];
  logic signed [IP_W-1:0]  inj_b [COLS];
  logic signed [IP_W-1:0]  a_pe  [ROWS][COLS];
  logic signed [IP_W-1:0]  b_pe  [ROWS][COLS];
  logic signed [ACC_W-1:0] acc   [ROWS][COLS];

  // Signed or unsigned IP_W x IP_W product, extended to ACC_W. Operands get
  // one extra bit so both modes share a single signed multiplier; a narrower
  // ACC_W simply keeps the low bits, which is the intended modulo wrap.
  function automatic logic signed [ACC_W-1:0] ext_mul(
    input logic signed [IP_W-1:0] a,
    input logic signed [IP_W-1:0] b,
    input logic                   sm
  );
    logic signed [IP_W:0]     ax;
    logic signed [IP_W:0]     bx;
    logic signed [2*IP_W+1:0] p;
    ax = {sm & a[IP_W-1], a};
    bx = {sm & b[IP_W-1], b};
    p  = ax * bx;
    return ACC_W'(p);
  endfunction

  assign job_start = (state == S_IDLE) && start;
  assign row_last  = (out_row == RW'(ROWS - 1));
  assign busy      = (state != S_IDLE);
  assign out_last  = out_valid && row_last;

  // Next-state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = (k_len == '0) ? S_FLUSH : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (beat_cnt == k_r - KW'(1))) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_cnt == FW'(ROWS + COLS - 2)) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && row_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control registers: state, job parameters, counters, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k_r          <= '0;
      mode_r       <= 1'b0;
      beat_cnt     <= '0;
      flush_cnt    <= '0;
      out_row      <= '0;
      done         <= 1'b0;
      cycles_count <= '0;
    end else begin
      state <= state_n;
      done  <= (state == S_DRAIN) && out_ready && row_last;
      if (job_start) begin
        k_r          <= k_len;
        mode_r       <= signed_mode;
        beat_cnt     <= '0;
        cycles_count <= '0;
      end else begin
        if (state != S_IDLE) cycles_count <= cycles_count + 32'd1;
        if (state == S_LOAD && in_valid) beat_cnt <= beat_cnt + KW'(1);
      end
      if (state == S_FLUSH && state_n == S_FLUSH) flush_cnt <= flush_cnt + FW'(1);
      else flush_cnt <= '0;
      if (state == S_DRAIN && out_ready) out_row <= row_last ? '0 : out_row + RW'(1);
    end
  end

  // Operand injection: real data only on an accepted beat, zeros otherwise.
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      inj_a[i] = (state == S_LOAD && in_valid) ? $signed(a_vec[i*IP_W +: IP_W]) : '0;
    for (int j = 0; j < COLS; j++)
      inj_b[j] = (state == S_LOAD && in_valid) ? $signed(b_vec[j*IP_W +: IP_W]) : '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic signed [IP_W-1:0] a_line_p [i+COLS];
    // Row i: i skew stages followed by one forwarding register per PE hop.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int d = 0; d < i + COLS; d++) a_line_p[d] <= '0;
      end else begin
        a_line_p[0] <= inj_a[i];
        for (int d = 1; d < i + COLS; d++) a_line_p[d] <= a_line_p[d-1];
      end
    end
    for (genvar j = 0; j < COLS; j++) begin : g_tap
      assign a_pe[i][j] = a_line_p[i+j];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic signed [IP_W-1:0] b_line_p [j+ROWS];
    // Column j: j skew stages followed by one forwarding register per PE hop.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int d = 0; d < j + ROWS; d++) b_line_p[d] <= '0;
      end else begin
        b_line_p[0] <= inj_b[j];
        for (int d = 1; d < j + ROWS; d++) b_line_p[d] <= b_line_p[d-1];
      end
    end
    for (genvar i = 0; i < ROWS; i++) begin : g_tap
      assign b_pe[i][j] = b_line_p[i+j];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_pe_r
    for (genvar j = 0; j < COLS; j++) begin : g_pe_c
      // PE accumulator: cleared on job start, then wraps modulo 2^ACC_W.
      always_ff @(posedge clk) begin
        if (rst || job_start) acc[i][j] <= '0;
        else acc[i][j] <= acc[i][j] + ext_mul(a_pe[i][j], b_pe[i][j], mode_r);
      end
    end
  end

  // Result row mux: the presented row follows out_row.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++) out_data[j*ACC_W +: ACC_W] = acc[out_row][j];
  end

endmodule

// File: tb/tb_systolic_array_stream.sv
// Bench for systolic_array_stream: 4x4 grid with 32-bit accumulators plus a
// 2x2 instance with 16-bit accumulators for the wrap case.
module tb_systolic_array_stream;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int IW = 8;
  localparam int AW = 32;
  localparam int KM = 15;
  localparam int KW = 4;

  logic            clk;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            signed_mode;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [R*IW-1:0] a_vec;
  logic [C*IW-1:0] b_vec;
  logic            out_valid;
  logic            out_ready;
  logic [C*AW-1:0] out_data;
  logic [1:0]      out_row;
  logic            out_last;
  logic            done;
  logic [31:0]     cycles_count;

  logic            h_start, h_sm, h_busy, h_in_valid, h_in_ready;
  logic [KW-1:0]   h_k;
  logic [15:0]     h_a, h_b;
  logic            h_out_valid, h_out_last, h_done;
  logic [31:0]     h_out_data;
  logic            h_out_row;
  logic [31:0]     h_cycles;

  systolic_array_stream #(.ROWS(R), .COLS(C), .IP_W(IW), .ACC_W(AW), .K_MAX(KM)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .done(done), .cycles_count(cycles_count)
  );

  systolic_array_stream #(.ROWS(2), .COLS(2), .IP_W(IW), .ACC_W(16), .K_MAX(KM)) dut16 (
    .clk(clk), .rst(rst), .start(h_start), .k_len(h_k), .signed_mode(h_sm),
    .busy(h_busy), .in_valid(h_in_valid), .in_ready(h_in_ready), .a_vec(h_a), .b_vec(h_b),
    .out_valid(h_out_valid), .out_ready(1'b1), .out_data(h_out_data), .out_row(h_out_row),
    .out_last(h_out_last), .done(h_done), .cycles_count(h_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [C*AW-1:0] data;
    int              row;
  } exp_t;

  typedef struct {
    int          k;
    bit          sm;
    bit          tog;
    int          pat;
    bit          use_const;
    logic [31:0] elem;
    int          cyc;
  } vec_t;

  exp_t       exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] am [KM][R];
  logic [7:0] bm [KM][C];

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Scoreboard: every row transfer is compared against the oldest expected row.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_row: got row %0d expected none", out_row);
      end else begin
        e = exp_q.pop_front();
        chk("row_data", out_data, e.data);
        chk("row_idx", 128'(out_row), 128'(e.row));
        chk("row_last", 128'(out_last), 128'(e.row == R - 1));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(int pat, int k);
    int v [C] = '{1, -2, 3, -4};
    for (int kk = 0; kk < KM; kk++) begin
      for (int i = 0; i < R; i++) begin
        case (pat)
          0:       am[kk][i] = (i == kk) ? 8'd1 : 8'd0;
          1:       am[kk][i] = 8'hFF;
          2:       am[kk][i] = 8'($urandom);
          default: am[kk][i] = 8'd0;
        endcase
      end
      for (int j = 0; j < C; j++) begin
        case (pat)
          0:       bm[kk][j] = 8'(v[j] * (kk + 1));
          1:       bm[kk][j] = 8'hFF;
          2:       bm[kk][j] = 8'($urandom);
          default: bm[kk][j] = 8'd0;
        endcase
      end
    end
    if (k > KM) $display("FAIL load_ops: got k %0d expected <= %0d", k, KM);
  endtask

  task automatic push_model(int k, bit sm);
    exp_t   e;
    longint s, va, vb;
    for (int i = 0; i < R; i++) begin
      e.row  = i;
      e.data = '0;
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          va = sm ? longint'($signed(am[kk][i])) : longint'(am[kk][i]);
          vb = sm ? longint'($signed(bm[kk][j])) : longint'(bm[kk][j]);
          s  = s + va * vb;
        end
        e.data[j*AW +: AW] = s[AW-1:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic push_const(logic [31:0] v);
    exp_t e;
    for (int i = 0; i < R; i++) begin
      e.row = i;
      for (int j = 0; j < C; j++) e.data[j*AW +: AW] = v;
      exp_q.push_back(e);
    end
  endtask

  task automatic begin_job(int k, bit sm);
    start       = 1'b1;
    k_len       = KW'(k);
    signed_mode = sm;
    tick();
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic feed(int k, bit tog);
    int beat = 0;
    int cyc  = 0;
    bit xfer;
    while (beat < k && cyc < 200) begin
      in_valid = tog ? (cyc % 2 == 0) : 1'b1;
      for (int i = 0; i < R; i++) a_vec[i*IW +: IW] = am[beat][i];
      for (int j = 0; j < C; j++) b_vec[j*IW +: IW] = bm[beat][j];
      xfer = in_valid && in_ready;
      tick();
      if (xfer) beat++;
      cyc++;
    end
    in_valid = 1'b0;
    if (beat < k) begin
      n_vec++;
      n_err++;
      $display("FAIL feed_timeout: got %0d beats expected %0d", beat, k);
    end
  endtask

  task automatic wait_done(int exp_cyc);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk("done_seen", 128'(done), 128'(1));
    chk("busy_at_done", 128'(busy), 128'(0));
    chk("cycles_count", 128'(cycles_count), 128'(exp_cyc));
    chk("rows_left", 128'(exp_q.size()), 128'(0));
    tick();
    chk("done_pulse", 128'(done), 128'(0));
  endtask

  initial begin
    vec_t tbl [6];
    int   n;
    int   r;
    int   beats;

    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   n;
    int   r;
    int   beats;

    tbl[0] = '{4, 1'b1, 1'b0, 0, 1'b0, 32'd0,      15};
    tbl[1] = '{4, 1'b1, 1'b1, 0, 1'b0, 32'd0,      18};
    tbl[2] = '{3, 1'b0, 1'b0, 1, 1'b1, 32'd195075, 14};
    tbl[3] = '{3, 1'b1, 1'b0, 1, 1'b1, 32'd3,      14};
    tbl[4] = '{7, 1'b1, 1'b0, 2, 1'b0, 32'd0,      18};
    tbl[5] = '{5, 1'b0, 1'b1, 2, 1'b0, 32'd0,      20};

    rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; a_vec = '0; b_vec = '0; out_ready = 1'b1;
    h_start = 1'b0; h_k = '0; h_sm = 1'b0; h_in_valid = 1'b0; h_a = '0; h_b = '0;
    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_row", 128'(out_row), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_cycles", 128'(cycles_count), 128'(0));
    rst = 1'b0;
    tick();

    for (int t = 0; t < 6; t++) begin
      load_ops(tbl[t].pat, tbl[t].k);
      if (tbl[t].use_const) push_const(tbl[t].elem);
      else push_model(tbl[t].k, tbl[t].sm);
      begin_job(tbl[t].k, tbl[t].sm);
      feed(tbl[t].k, tbl[t].tog);
      wait_done(tbl[t].cyc);
    end

    // Backpressure while row 1 is presented.
    load_ops(0, 4);
    push_model(4, 1'b1);
    begin_job(4, 1'b1);
    feed(4, 1'b0);
    n = 0;
    while (!(out_valid && out_row == 2'd1) && n < 100) begin
      tick();
      n++;
    end
    chk("row1_reached", 128'(out_row), 128'(1));
    out_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_row", 128'(out_row), 128'(1));
      chk("stall_data", out_data, exp_q[0].data);
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_done", 128'(done), 128'(0));
    end
    out_ready = 1'b1;
    wait_done(20);

    // Reset during FLUSH, then a k_len=0 job with an ignored start while busy.
    load_ops(2, 2);
    push_model(2, 1'b1);
    begin_job(2, 1'b1);
    feed(2, 1'b0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("rst_flush_valid", 128'(out_valid), 128'(0));
    chk("rst_flush_busy", 128'(busy), 128'(0));
    chk("rst_flush_cycles", 128'(cycles_count), 128'(0));
    tick();
    chk("rst_flush_valid2", 128'(out_valid), 128'(0));
    rst = 1'b0;
    tick();
    push_const(32'd0);
    begin_job(0, 1'b1);
    chk("k0_no_load", 128'(in_ready), 128'(0));
    start = 1'b1; k_len = 4'd5; signed_mode = 1'b0;
    tick();
    tick();
    start = 1'b0;
    wait_done(11);

    // 16-bit accumulators: 5 x 127*127 wraps to 15109.
    h_start = 1'b1; h_k = 4'd5; h_sm = 1'b1;
    tick();
    h_start = 1'b0;
    h_in_valid = 1'b1; h_a = {8'd127, 8'd127}; h_b = {8'd127, 8'd127};
    beats = 0;
    n = 0;
    while (beats < 5 && n < 50) begin
      r = int'(h_in_ready);
      tick();
      beats += r;
      n++;
    end
    h_in_valid = 1'b0;
    r = 0;
    n = 0;
    while (!h_done && n < 100) begin
      tick();
      if (h_out_valid) begin
        chk("wrap_data", 128'(h_out_data), 128'({16'd15109, 16'd15109}));
        chk("wrap_row", 128'(h_out_row), 128'(r));
        r++;
      end
      n++;
    end
    chk("wrap_rows", 128'(r), 128'(2));
    chk("wrap_done", 128'(h_done), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_array_stream.md
Name: systolic_array_stream

Overview:
- Second-generation output-stationary GEMM engine. Computes C = A×B, with A sized ROWS×K and B sized K×COLS.
- K is runtime-programmable, 1..K_MAX.
- Operands arrive as a valid/ready stream of paired column/row vectors. The block skews them internally across the PE grid.
- Results are drained row by row on a backpressurable output stream. This replaces a flat all-accumulator output bus and a fixed countdown timer.
- Sits between the operand-fetch DMA and the result writeback buffer.

Parameters:
- ROWS, 16, PE grid rows (≥1).
- COLS, 16, PE grid columns (≥1).
- IP_W, 8, operand element width.
- ACC_W, 32, accumulator and result element width (≥2*IP_W).
- K_MAX, 1024, maximum reduction length. KW = $clog2(K_MAX+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse that begins a job; sampled only in IDLE
- k_len  in  KW  reduction length; captured on accepted start
- signed_mode  in  1  1 = operands signed, 0 = unsigned; captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid&in_ready
- a_vec  in  ROWS*IP_W  A column k; element i at [i*IP_W +: IP_W]
- b_vec  in  COLS*IP_W  B row k; element j at [j*IP_W +: IP_W]
- out_valid  out  1  result row valid
- out_ready  in  1  downstream accepts row
- out_data  out  COLS*ACC_W  C row r; element j at [j*ACC_W +: ACC_W]
- out_row  out  $clog2(ROWS)  index of the row currently presented (width ≥1)
- out_last  out  1  high with the final row (r = ROWS-1)
- done  out  1  one-cycle pulse after the last row transfers
- cycles_count  out  32  cycles spent in LOAD+FLUSH+DRAIN for the last/current job

Behaviour:
Reset:
- All of the following are forced to 0 and the state to IDLE: accumulators, skew registers, counters, and the outputs busy, in_ready, out_valid, out_last, out_row, done, cycles_count.
- Reset mid-job aborts the job. No partial output is produced.

States:
- IDLE: start=1 captures k_len and signed_mode, clears all accumulators and cycles_count, and moves to LOAD (or to FLUSH if k_len=0). Start in any other state is ignored.
- LOAD: in_ready=1.
  - Each transfer injects a_vec/b_vec into the skew lines and increments the beat counter.
  - A cycle with no transfer injects zero operands (a bubble). Bubbles do not change results.
  - After beat k_len-1 transfers, move to FLUSH.
- FLUSH: in_ready=0. Zeros are injected for exactly ROWS+COLS-1 cycles, then move to DRAIN.
- DRAIN: out_valid=1 and out_data = C row out_row, starting at row 0.
  - out_row increments on each out_valid&out_ready.
  - If out_ready=0, out_data and out_row are held stable.
  - out_last = (out_row==ROWS-1).
  - Transfer of the last row moves to IDLE and pulses done for 1 cycle.

Skew and timing:
- A beat transferred at cycle t feeds row i delayed by i cycles and column j delayed by j cycles.
- PE(i,j) accumulates the product a_i·b_j at the clock edge ending cycle t+1+i+j.
- Horizontal and vertical forwarding between PEs is one register per hop.

Arithmetic:
- Each product is the signed or unsigned product of the two IP_W-bit operands, per the captured signed_mode.
- The product is sign- or zero-extended to ACC_W, then accumulated modulo 2^ACC_W (wrap, no saturation).

cycles_count:
- Increments every cycle in LOAD, FLUSH and DRAIN.
- Frozen in IDLE; it holds the final value until the next accepted start.

Boundaries:
- k_len=0: skips LOAD and drains all-zero rows.
- k_len>K_MAX: behaviour undefined; verification excludes it.
- done and a new start in the same cycle: the start is honoured, because the state is already IDLE.
- Minimum job latency with no bubbles and out_ready=1: k_len + (ROWS+COLS-1) + ROWS cycles from the first LOAD cycle to done.

Test Plan:
- ROWS=COLS=4, signed_mode=1, k_len=4, A=identity, B rows [1,-2,3,-4]·(k+1), in_valid always high, out_ready always high → out_data rows equal B rows exactly, out_last on row 3, done at cycle 4+7+4=15 after LOAD entry, cycles_count=15.
- Same job with in_valid toggled 1,0,1,0... → identical results; LOAD duration 7 cycles; cycles_count=18.
- signed_mode=0, all operands 8'hFF, k_len=3 → every element 3·65025=195075; with signed_mode=1 every element =3.
- ACC_W=16, operands 127·127 with k_len=5 → each element (5·16129) mod 65536 = 15109 (wrap).
- out_ready low for 5 cycles while row 1 is presented → out_row=1 and out_data stable throughout; remaining rows then delivered in order; done only after row 3 transfers.
- rst asserted in FLUSH, then a new job with k_len=0 → out_valid=0 during reset; new job drains four all-zero rows; start asserted while busy is ignored.
